// File: rtl/seg7_readback.sv
// seg7_readback: receiver and checker for a two-digit 7-segment display bus.
//
// Both 8-bit segment buses (Dgfedcba) pass through a two-stage synchroniser.
// The decimal point is then dropped, leaving a 14-bit sample. A pattern is
// accepted once STABLE_CYCLES identical samples have been seen on CE=1 cycles.
// Each accepted pattern is decoded to BCD, and the value must be the previous
// value plus one, modulo 100.
//
// Ports:
//   C            clock, rising edge
//   CLR          asynchronous active-high reset
//   CE           clock enable for everything except the synchroniser
//   seg_in1      ones-digit segment pattern, Dgfedcba
//   seg_in2      tens-digit segment pattern, Dgfedcba
//   digit_lo     last accepted ones digit (BCD)
//   digit_hi     last accepted tens digit (BCD)
//   value_valid  high once any valid value has been accepted
//   new_value    one-cycle pulse when the digits update
//   pattern_err  one-cycle pulse when an accepted pattern is not a legal digit
//   seq_err      one-cycle pulse when a new value is not previous + 1 (mod 100)
//   err_count    saturating count of pattern_err and seq_err events
module seg7_readback #(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned CNT_W         = 5
) (
   input  logic       C,
   input  logic       CLR,
   input  logic       CE,
   input  logic [7:0] seg_in1,
   input  logic [7:0] seg_in2,
   output logic [3:0] digit_lo,
   output logic [3:0] digit_hi,
   output logic       value_valid,
   output logic       new_value,
   output logic       pattern_err,
   output logic       seq_err,
   output logic [7:0] err_count
);

   typedef enum logic [0:0] {StSettle, StStable} state_e;

   // The counter holds (identical samples seen - 1). Acceptance happens on the
   // edge that brings it to STABLE_CYCLES-1.
   localparam logic [CNT_W-1:0] AcceptCnt = CNT_W'(STABLE_CYCLES - 2);

   // Returns {legal, digit} for a 7-bit gfedcba pattern.
   function automatic logic [4:0] decode_seg(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'h3F:   res = {1'b1, 4'd0};
         7'h06:   res = {1'b1, 4'd1};
         7'h5B:   res = {1'b1, 4'd2};
         7'h4F:   res = {1'b1, 4'd3};
         7'h66:   res = {1'b1, 4'd4};
         7'h6D:   res = {1'b1, 4'd5};
         7'h7D:   res = {1'b1, 4'd6};
         7'h07:   res = {1'b1, 4'd7};
         7'h7F:   res = {1'b1, 4'd8};
         7'h6F:   res = {1'b1, 4'd9};
         default: res = {1'b0, 4'd0};
      endcase
      return res;
   endfunction

   logic [15:0]      sync1_q, sync2_q;
   logic [13:0]      sample;
   logic [1:0]       dp_unused;

   state_e           state_q, state_d;
   logic [13:0]      prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       lo_q, lo_d, hi_q, hi_d;
   logic             valid_q, valid_d;
   logic             new_q, new_d;
   logic             perr_q, perr_d;
   logic             serr_q, serr_d;
   logic [7:0]       err_q, err_d;

   logic             same;
   logic             accept;
   logic [4:0]       dec_lo, dec_hi;
   logic [3:0]       succ_lo, succ_hi;

   // The synchroniser runs on every clock edge, whatever CE is.
   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {seg_in2, seg_in1};
         sync2_q <= sync1_q;
      end
   end

   // The decimal points are synchronised but play no part in the checks.
   assign dp_unused = {sync2_q[15], sync2_q[7]};
   assign sample    = {sync2_q[14:8], sync2_q[6:0]};
   assign same      = (sample == prev_q);
   assign dec_lo    = decode_seg(sample[6:0]);
   assign dec_hi    = decode_seg(sample[13:7]);

   // BCD successor of the held value. 99 wraps to 00.
   always_comb begin
      succ_lo = lo_q + 4'd1;
      succ_hi = hi_q;
      if (lo_q == 4'd9) begin
         succ_lo = 4'd0;
         succ_hi = (hi_q == 4'd9) ? 4'd0 : hi_q + 4'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      valid_d = valid_q;
      new_d   = 1'b0;
      perr_d  = 1'b0;
      serr_d  = 1'b0;
      err_d   = err_q;
      accept  = 1'b0;

      if (CE) begin
         prev_d = sample;
         unique case (state_q)
            StSettle: begin
               if (!same) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == AcceptCnt) begin
                     accept  = 1'b1;
                     state_d = StStable;
                  end
               end
            end
            StStable: begin
               if (!same) begin
                  cnt_d   = '0;
                  state_d = StSettle;
               end
            end
            default: state_d = StSettle;
         endcase

         if (accept) begin
            if (!dec_lo[4] || !dec_hi[4]) begin
               perr_d = 1'b1;
            end else if (!valid_q || dec_lo[3:0] != lo_q || dec_hi[3:0] != hi_q) begin
               lo_d    = dec_lo[3:0];
               hi_d    = dec_hi[3:0];
               valid_d = 1'b1;
               new_d   = 1'b1;
               // The first value after reset has no predecessor to check against.
               serr_d  = valid_q && (dec_lo[3:0] != succ_lo || dec_hi[3:0] != succ_hi);
            end
         end

         if ((perr_d || serr_d) && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
         end
      end
   end

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         state_q <= StSettle;
         prev_q  <= '0;
         cnt_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         valid_q <= 1'b0;
         new_q   <= 1'b0;
         perr_q  <= 1'b0;
         serr_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         valid_q <= valid_d;
         new_q   <= new_d;
         perr_q  <= perr_d;
         serr_q  <= serr_d;
         err_q   <= err_d;
      end
   end

   assign digit_lo    = lo_q;
   assign digit_hi    = hi_q;
   assign value_valid = valid_q;
   assign new_value   = new_q;
   assign pattern_err = perr_q;
   assign seq_err     = serr_q;
   assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Testbench for seg7_readback. Random and directed segment patterns are checked
// against a run-length reference model. Each expected output event is queued
// with the cycle it is due on. A monitor pops an entry and compares it whenever
// the DUT pulses new_value, pattern_err or seq_err.
module tb_seg7_readback;

   localparam int S = 4;

   logic       C = 1'b0;
   logic       CLR;
   logic       CE;
   logic [7:0] seg_in1, seg_in2;
   logic [3:0] digit_lo, digit_hi;
   logic       value_valid, new_value, pattern_err, seq_err;
   logic [7:0] err_count;

   seg7_readback #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
      .C           (C),
      .CLR         (CLR),
      .CE          (CE),
      .seg_in1     (seg_in1),
      .seg_in2     (seg_in2),
      .digit_lo    (digit_lo),
      .digit_hi    (digit_hi),
      .value_valid (value_valid),
      .new_value   (new_value),
      .pattern_err (pattern_err),
      .seq_err     (seq_err),
      .err_count   (err_count)
   );

   always #5 C = ~C;

   typedef struct {
      int cyc;
      bit perr;
      bit serr;
      bit nv;
      int lo;
      int hi;
      bit vv;
      int ec;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_no = 0;
   bit   rand_ce = 0;

   logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   // Reference model state
   bit [13:0] hist[$];
   bit [13:0] last;
   int        run;
   bit        settled;
   bit        have;
   int        held;
   int        m_lo, m_hi, m_err;
   bit        m_vv;

   function automatic int decode(input bit [6:0] p);
      for (int i = 0; i < 10; i++) if (seg_tab[i][6:0] == p) return i;
      return -1;
   endfunction

   task automatic model_reset();
      hist.delete();
      hist.push_back(14'd0);
      hist.push_back(14'd0);
      last = 0; run = 1; settled = 0;
      have = 0; held = 0;
      m_lo = 0; m_hi = 0; m_err = 0; m_vv = 0;
   endtask

   task automatic model_accept(input bit [13:0] s);
      exp_t e;
      int   lo, hi, v;
      lo = decode(s[6:0]);
      hi = decode(s[13:7]);
      e.cyc = edge_no + 1;
      e.perr = 0; e.serr = 0; e.nv = 0;
      if (lo < 0 || hi < 0) begin
         e.perr = 1;
      end else begin
         v = hi * 10 + lo;
         if (have && v == held) return;
         e.nv = 1;
         if (have && v != (held + 1) % 100) e.serr = 1;
         have = 1; held = v; m_lo = lo; m_hi = hi; m_vv = 1;
      end
      if ((e.perr || e.serr) && m_err < 255) m_err++;
      e.lo = m_lo; e.hi = m_hi; e.vv = m_vv; e.ec = m_err;
      q.push_back(e);
   endtask

   // The FSM sees, at each edge, the input that was driven two edges earlier.
   task automatic model_edge(input bit ce, input logic [7:0] s1, input logic [7:0] s2);
      bit [13:0] s;
      hist.push_back({s2[6:0], s1[6:0]});
      s = hist.pop_front();
      if (!ce) return;
      if (s != last) begin
         last = s; run = 1; settled = 0;
      end else if (!settled) begin
         run++;
         if (run == S) begin
            settled = 1;
            model_accept(s);
         end
      end
   endtask

   // Called at a negedge; returns at the next negedge.
   task automatic step(input bit ce, input logic [7:0] s1, input logic [7:0] s2);
      CE = ce; seg_in1 = s1; seg_in2 = s2;
      model_edge(ce, s1, s2);
      @(posedge C);
      edge_no++;
      @(negedge C);
   endtask

   task automatic hold(input logic [7:0] s1, input logic [7:0] s2, input int n);
      bit ce;
      for (int i = 0; i < n; i++) begin
         ce = rand_ce ? ($urandom_range(0, 9) != 0) : 1'b1;
         step(ce, s1, s2);
      end
   endtask

   task automatic check_cleared(input string name);
      checks++;
      if ({digit_lo, digit_hi, value_valid, new_value, pattern_err, seq_err, err_count} !== '0) begin
         errors++;
         $display("FAIL %s got lo=%0d hi=%0d vv=%b nv=%b pe=%b se=%b ec=%0d required all zero",
                  name, digit_lo, digit_hi, value_valid, new_value, pattern_err, seq_err,
                  err_count);
      end
   endtask

   // Called at a negedge; returns at a negedge with the model reset.
   task automatic do_reset();
      #2 CLR = 1'b1;
      #1 check_cleared("reset_async");
      repeat (2) @(posedge C);
      @(negedge C);
      check_cleared("reset_hold");
      CLR = 1'b0;
      q.delete();
      model_reset();
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge C);
         if (!CLR) begin
            if (new_value || pattern_err || seq_err) begin
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL spurious_event cycle=%0d got nv=%b pe=%b se=%b required no event",
                           edge_no, new_value, pattern_err, seq_err);
               end else begin
                  e = q.pop_front();
                  if (e.cyc != edge_no || e.perr != pattern_err || e.serr != seq_err ||
                      e.nv != new_value || e.lo != int'(digit_lo) || e.hi != int'(digit_hi) ||
                      e.vv != value_valid || e.ec != int'(err_count)) begin
                     errors++;
                     $display({"FAIL event got cyc=%0d pe=%b se=%b nv=%b lo=%0d hi=%0d vv=%b ec=%0d",
                               " required cyc=%0d pe=%b se=%b nv=%b lo=%0d hi=%0d vv=%b ec=%0d"},
                              edge_no, pattern_err, seq_err, new_value, digit_lo, digit_hi,
                              value_valid, err_count, e.cyc, e.perr, e.serr, e.nv, e.lo, e.hi,
                              e.vv, e.ec);
                  end
               end
            end else if (q.size() > 0 && q[0].cyc <= edge_no) begin
               checks++;
               errors++;
               $display("FAIL missed_event cycle=%0d got no pulse required pe=%b se=%b nv=%b",
                        edge_no, q[0].perr, q[0].serr, q[0].nv);
               void'(q.pop_front());
            end
         end
      end
   end

   // Stimulus
   initial begin
      int         kind, v, len;
      logic [7:0] a, b;
      CLR = 1'b1; CE = 1'b0; seg_in1 = 8'h00; seg_in2 = 8'h00;
      repeat (3) @(posedge C);
      @(negedge C);
      check_cleared("power_up");
      CLR = 1'b0;
      model_reset();

      // Blank display: illegal pattern
      hold(8'h00, 8'h00, 8);
      // 01, 02, then 05 (sequence error)
      hold(8'h06, 8'h3F, 10);
      hold(8'h5B, 8'h3F, 10);
      hold(8'h6D, 8'h3F, 10);
      // Glitch shorter than the filter, then back
      hold(8'h66, 8'h3F, S - 1);
      hold(8'h6D, 8'h3F, 10);
      // 99 with decimal points set, then the legal wrap to 00
      hold(8'hEF, 8'hEF, 10);
      hold(8'h3F, 8'h3F, 10);
      // Reset two edges into settling, then the first value after reset
      hold(8'h06, 8'h3F, 4);
      do_reset();
      hold(8'h5B, 8'h3F, 10);
      // Reset while a pulse is on the outputs
      hold(8'h4F, 8'h3F, 6);
      do_reset();

      // Saturate the error counter
      for (int k = 0; k < 265; k++) hold((k % 2 == 0) ? 8'h01 : 8'h00, 8'h00, 6);

      // Randomised traffic with CE gaps
      do_reset();
      rand_ce = 1;
      for (int k = 0; k < 300; k++) begin
         kind = $urandom_range(0, 99);
         v = (kind < 60 && have) ? (held + 1) % 100 : $urandom_range(0, 99);
         a = seg_tab[v % 10] | {$urandom_range(0, 1) == 1, 7'b0};
         b = seg_tab[v / 10] | {$urandom_range(0, 1) == 1, 7'b0};
         if (kind >= 75 && kind < 85) a = 8'($urandom);
         len = (kind >= 85) ? $urandom_range(1, S - 1) : $urandom_range(S, S + 6);
         hold(a, b, len);
      end
      rand_ce = 0;
      hold(8'h06, 8'h3F, 12);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d pending required 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
